outsplitter_bank: RTL

//  Parametrised successor to the byte-to-bit output splitter. Consumes the

---
 rtl/outsplit_pkg.sv | 28 ++
 rtl/pulse_stretch_cell.sv | 35 +++
 rtl/outsplitter_bank.sv | 125 ++++++++++++
 3 files changed

// File: rtl/outsplit_pkg.sv
// Shared definitions for the byte-driven output bank splitter:
// command mode codes, command FSM encodings and command byte field helpers.
package outsplit_pkg;

    // Command mode field, cmd[7:6]
    localparam logic [1:0] MODE_SET    = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_PULSE  = 2'b10;
    localparam logic [1:0] MODE_CLEAR  = 2'b11;

    // Command FSM states
    localparam logic [1:0] S_CMD  = 2'd0;
    localparam logic [1:0] S_DATA = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    // Command byte layout: [7:6] mode, [5:0] bank
    localparam int CMD_MODE_LSB = 6;
    localparam int CMD_BANK_W   = 6;

    function automatic logic [1:0] cmd_mode(input logic [7:0] b);
        return b[7:CMD_MODE_LSB];
    endfunction

    function automatic logic [CMD_BANK_W-1:0] cmd_bank(input logic [7:0] b);
        return b[CMD_BANK_W-1:0];
    endfunction

endpackage

// File: rtl/pulse_stretch_cell.sv
// One-bit pulse stretcher: load arms the counter to PULSE_CYCLES, clear
// zeroes it, otherwise it counts down to 0. active is high while armed.
module pulse_stretch_cell #(
    parameter int PULSE_CYCLES = 1000000,
    parameter int CNT_W        = $clog2(PULSE_CYCLES + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_clear,
    output logic o_active
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: a reload beats expiry on the same edge, clear beats decrement
    always_comb begin
        cnt_d = cnt_q;
        if (i_load)
            cnt_d = CNT_W'(PULSE_CYCLES);
        else if (i_clear)
            cnt_d = '0;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    // Counter register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign o_active = (cnt_q != '0);

endmodule

// File: rtl/outsplitter_bank.sv
// Byte-stream command decoder driving NUM_BANKS x 8 output bits.
// Frames are [cmd][data] (CLEAR is cmd only). Each bit is its level
// register OR'd with its own pulse stretcher.
module outsplitter_bank #(
    parameter int NUM_BANKS    = 4,
    parameter int PULSE_CYCLES = 1000000,
    parameter int CNT_W        = $clog2(PULSE_CYCLES + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [7:0]             i_byte,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [NUM_BANKS*8-1:0] o_bits,
    output logic                   o_err
);
    import outsplit_pkg::*;

    localparam int NB = NUM_BANKS * 8;

    logic                  rdy_q;
    logic [1:0]            state_q, state_d;
    logic [1:0]            mode_q, mode_d;
    logic [CMD_BANK_W-1:0] bank_q, bank_d;
    logic                  err_q, err_d;
    logic [NB-1:0]         lvl_q, lvl_d;
    logic [NB-1:0]         load, clear, active;

    logic                  accept;
    logic [1:0]            c_mode;
    logic [CMD_BANK_W-1:0] c_bank;
    logic                  bank_bad;

    assign accept   = i_valid & rdy_q;
    assign c_mode   = cmd_mode(i_byte);
    assign c_bank   = cmd_bank(i_byte);
    // Extra bit so NUM_BANKS=64 compares correctly against a 6-bit bank
    assign bank_bad = {1'b0, c_bank} >= 7'(NUM_BANKS);

    // Command FSM: latch mode/bank for two-byte frames, flag bad banks
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        bank_d  = bank_q;
        err_d   = 1'b0;
        if (accept) begin
            case (state_q)
                S_CMD: begin
                    if (bank_bad) begin
                        err_d   = 1'b1;
                        state_d = (c_mode == MODE_CLEAR) ? S_CMD : S_DROP;
                    end else if (c_mode != MODE_CLEAR) begin
                        state_d = S_DATA;
                        mode_d  = c_mode;
                        bank_d  = c_bank;
                    end
                end
                default: state_d = S_CMD;  // S_DATA, S_DROP, or unused code
            endcase
        end
    end

    // Bank writes: levels update here, counters get load/clear strobes
    always_comb begin
        lvl_d = lvl_q;
        load  = '0;
        clear = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (accept && state_q == S_CMD && c_mode == MODE_CLEAR &&
                c_bank == CMD_BANK_W'(k)) begin
                lvl_d[k*8 +: 8] = '0;
                clear[k*8 +: 8] = '1;
            end
            if (accept && state_q == S_DATA && bank_q == CMD_BANK_W'(k)) begin
                case (mode_q)
                    MODE_SET: begin
                        lvl_d[k*8 +: 8] = i_byte;
                        clear[k*8 +: 8] = '1;
                    end
                    MODE_TOGGLE: lvl_d[k*8 +: 8] = lvl_q[k*8 +: 8] ^ i_byte;
                    MODE_PULSE:  load[k*8 +: 8]  = i_byte;
                    default: ;
                endcase
            end
        end
    end

    // Control and level registers; ready comes up one cycle after reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdy_q   <= 1'b0;
            state_q <= S_CMD;
            mode_q  <= MODE_SET;
            bank_q  <= '0;
            err_q   <= 1'b0;
            lvl_q   <= '0;
        end else begin
            rdy_q   <= 1'b1;
            state_q <= state_d;
            mode_q  <= mode_d;
            bank_q  <= bank_d;
            err_q   <= err_d;
            lvl_q   <= lvl_d;
        end
    end

    for (genvar i = 0; i < NB; i++) begin : g_cell
        pulse_stretch_cell #(
            .PULSE_CYCLES (PULSE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_cell (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_load   (load[i]),
            .i_clear  (clear[i]),
            .o_active (active[i])
        );
    end

    // Output OR stage over registered level and counter state
    assign o_bits  = lvl_q | active;
    assign o_err   = err_q;
    assign o_ready = rdy_q;

endmodule
